uart_tx_periph: RTL and testbench

UART_TX_PERIPH -- requirements
Module: uart_tx_periph

---
 rtl/uart_tx_periph.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: byte FIFO fed by stores to TXDATA, 8N1 serialiser,
// STATUS/CTRL registers readable through a combinational load path.
module uart_tx_periph #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  output logic [31:0] data_rd,
  output logic        tx,
  output logic        busy
);

  localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BaudLast = BW'(BAUD_DIV - 1);
  localparam logic [AW:0]   FifoFull = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            enable_q, enable_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      mem [FIFO_DEPTH];

  logic sel_txdata, sel_status, sel_ctrl;
  logic full, empty, push_req, push, pop, start_ok, baud_end;

  logic unused;
  assign unused = ^{addr[31:4], addr[1:0], mask[3:1], data_wr[31:8]};

  assign sel_txdata = cs & wr & mask[0] & (addr[3:2] == 2'd0);
  assign sel_status = cs & wr & mask[0] & (addr[3:2] == 2'd1);
  assign sel_ctrl   = cs & wr & mask[0] & (addr[3:2] == 2'd2);

  assign full     = (count_q == FifoFull);
  assign empty    = (count_q == '0);
  assign push_req = sel_txdata;
  // A full FIFO still accepts a push when the serialiser pops on the same edge.
  assign push     = push_req & (~full | pop);
  assign start_ok = enable_q & ~empty;
  assign baud_end = (baud_q == BaudLast);

  always_comb begin
    enable_d = enable_q;
    ovf_d    = ovf_q;
    count_d  = count_q;
    if (sel_ctrl) enable_d = data_wr[0];
    if (push_req & full & ~pop) ovf_d = 1'b1;
    else if (sel_status & data_wr[3]) ovf_d = 1'b0;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          pop     = 1'b1;
          shift_d = mem[rd_ptr_q];
          state_d = StStart;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
          baud_d  = '0;
        end
      end
      StStart: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = StData;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = StStop;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 1'b1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_end) begin
          baud_d = '0;
          // Chain straight into the next start bit so queued bytes go out gap-free.
          if (start_ok) begin
            pop     = 1'b1;
            shift_d = mem[rd_ptr_q];
            state_d = StStart;
            tx_d    = 1'b0;
          end else begin
            state_d = StIdle;
            busy_d  = 1'b0;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      enable_q <= enable_d;
      ovf_q    <= ovf_d;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= data_wr[7:0];
  end

  always_comb begin
    data_rd = '0;
    if (cs & ~wr) begin
      case (addr[3:2])
        2'd1:    data_rd = {28'b0, ovf_q, busy_q, empty, full};
        2'd2:    data_rd = {31'b0, enable_q};
        default: data_rd = '0;
      endcase
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_periph.sv
// Bench for uart_tx_periph: register-access vector table, directed frame/FIFO/reset
// sequences, and random byte bursts checked against a per-cycle 8N1 waveform model.
module tb_uart_tx_periph;

  localparam int unsigned Baud  = 4;
  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic [3:0]  mask = '0;
  logic [31:0] addr = '0;
  logic [31:0] data_wr = '0;
  logic [31:0] data_rd;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  uart_tx_periph #(
    .BAUD_DIV  (Baud),
    .FIFO_DEPTH(Depth)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .cs     (cs),
    .wr     (wr),
    .mask   (mask),
    .addr   (addr),
    .data_wr(data_wr),
    .data_rd(data_rd),
    .tx     (tx),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        cs;
    logic        wr;
    logic [3:0]  addr;
    logic [3:0]  mask;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; data_wr = d; mask = m;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; mask = '0;
  endtask

  task automatic read_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    cs = 1'b1; wr = 1'b0; addr = a;
    #1 check(name, data_rd, exp);
    cs = 1'b0;
  endtask

  // Waits for busy; exp_wait >= 0 also checks how many negedges that took.
  task automatic wait_busy(input int exp_wait);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b1) check("busy_timeout", {31'b0, busy}, 32'd1);
    else if (exp_wait >= 0) check("start_latency", n, exp_wait);
  endtask

  task automatic wait_idle(input int exp_wait);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) check("idle_timeout", {31'b0, busy}, 32'd0);
    else check("frame_end_time", n, exp_wait);
  endtask

  // Current negedge is cycle 0 of the first frame; frames of exp_q must follow gap-free.
  task automatic check_wave(input string name);
    int total;
    total = exp_q.size() * 10 * Baud;
    for (int c = 0; c < total; c++) begin
      logic [7:0] b;
      int bitn;
      logic e;
      if (c > 0) @(negedge clk);
      b    = exp_q[c / (10 * Baud)];
      bitn = (c % (10 * Baud)) / Baud;
      e    = (bitn == 0) ? 1'b0 : (bitn == 9) ? 1'b1 : b[bitn-1];
      check({name, "_tx"}, {31'b0, tx}, {31'b0, e});
      check({name, "_busy"}, {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    check({name, "_end_busy"}, {31'b0, busy}, 32'd0);
    check({name, "_end_tx"}, {31'b0, tx}, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[18];
    logic [31:0] d;
    logic [3:0]  m;
    int          n;

    vecs[0]  = '{1'b1, 1'b0, 4'h4, 4'h0, 32'h0,        32'h2};
    vecs[1]  = '{1'b1, 1'b0, 4'h8, 4'h0, 32'h0,        32'h0};
    vecs[2]  = '{1'b1, 1'b0, 4'hC, 4'h0, 32'h0,        32'h0};
    vecs[3]  = '{1'b1, 1'b1, 4'h8, 4'h0, 32'h1,        32'h0};
    vecs[4]  = '{1'b1, 1'b0, 4'h8, 4'h0, 32'h0,        32'h0};
    vecs[5]  = '{1'b1, 1'b1, 4'h8, 4'hF, 32'hFFFFFFFE, 32'h0};
    vecs[6]  = '{1'b1, 1'b0, 4'h8, 4'h0, 32'h0,        32'h0};
    vecs[7]  = '{1'b1, 1'b1, 4'h0, 4'hE, 32'hAA,       32'h0};
    vecs[8]  = '{1'b0, 1'b1, 4'h0, 4'h1, 32'hAA,       32'h0};
    vecs[9]  = '{1'b1, 1'b0, 4'h4, 4'h0, 32'h0,        32'h2};
    vecs[10] = '{1'b1, 1'b1, 4'h8, 4'h1, 32'h1,        32'h0};
    vecs[11] = '{1'b1, 1'b0, 4'h8, 4'h0, 32'h0,        32'h1};
    vecs[12] = '{1'b1, 1'b1, 4'hC, 4'hF, 32'h0,        32'h0};
    vecs[13] = '{1'b1, 1'b0, 4'h8, 4'h0, 32'h0,        32'h1};
    vecs[14] = '{1'b1, 1'b0, 4'hC, 4'h0, 32'h0,        32'h0};
    vecs[15] = '{1'b0, 1'b0, 4'h8, 4'h0, 32'h0,        32'h0};
    vecs[16] = '{1'b1, 1'b1, 4'h8, 4'h1, 32'h0,        32'h0};
    vecs[17] = '{1'b1, 1'b0, 4'h8, 4'h0, 32'h0,        32'h0};

    repeat (3) @(negedge clk);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      cs = vecs[i].cs; wr = vecs[i].wr; addr = {28'b0, vecs[i].addr};
      mask = vecs[i].mask; data_wr = vecs[i].data;
      if (!vecs[i].wr) begin
        #1 check($sformatf("vec%0d", i), data_rd, vecs[i].exp);
      end
    end
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; mask = '0;

    // Single frame, start one edge after the push.
    bus_write(32'h8, 32'h1, 4'h1);
    bus_write(32'h0, 32'h55, 4'h1);
    wait_busy(1);
    exp_q = '{8'h55};
    check_wave("frame55");

    // Overflow then back-to-back burst of the four retained bytes.
    bus_write(32'h8, 32'h0, 4'h1);
    for (int k = 1; k <= 5; k++) bus_write(32'h0, k, 4'h1);
    read_check("status_full_ovf", 32'h4, 32'h9);
    bus_write(32'h8, 32'h1, 4'h1);
    wait_busy(1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    check_wave("burst");
    read_check("status_after_burst", 32'h4, 32'hA);
    bus_write(32'h4, 32'h8, 4'h0);
    read_check("ovf_clear_masked", 32'h4, 32'hA);
    bus_write(32'h4, 32'h8, 4'h1);
    read_check("ovf_clear", 32'h4, 32'h2);

    // Push into a full FIFO on the same edge as the first pop.
    bus_write(32'h8, 32'h0, 4'h1);
    for (int k = 0; k < 4; k++) bus_write(32'h0, 32'h10 + k, 4'h1);
    read_check("status_full", 32'h4, 32'h1);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = 32'h8; data_wr = 32'h1; mask = 4'h1;
    @(negedge clk);
    addr = 32'h0; data_wr = 32'h14;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; mask = '0;
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    check_wave("full_pushpop");
    read_check("status_no_ovf", 32'h4, 32'h2);

    // Reset at cycle 13 of a frame (inside a zero data bit) with a second byte queued.
    bus_write(32'h0, 32'h00, 4'h1);
    bus_write(32'h0, 32'h3C, 4'h1);
    repeat (12) @(negedge clk);
    check("pre_reset_tx", {31'b0, tx}, 32'd0);
    #2 rst = 1'b0;
    #1 check("reset_mid_tx", {31'b0, tx}, 32'd1);
    check("reset_mid_busy", {31'b0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    read_check("status_after_reset", 32'h4, 32'h2);
    read_check("ctrl_after_reset", 32'h8, 32'h0);
    bus_write(32'h8, 32'h1, 4'h1);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      check("flushed_tx", {31'b0, tx}, 32'd1);
    end

    // Disable during the first of two frames: it completes, the second waits.
    bus_write(32'h0, 32'h81, 4'h1);
    bus_write(32'h0, 32'h42, 4'h1);
    bus_write(32'h8, 32'h0, 4'h1);
    wait_idle(37);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("disabled_tx", {31'b0, tx}, 32'd1);
    end
    read_check("status_one_left", 32'h4, 32'h0);
    bus_write(32'h8, 32'h1, 4'h1);
    wait_busy(1);
    exp_q = '{8'h42};
    check_wave("retained");

    // Random bursts loaded while disabled, then released.
    for (int it = 0; it < 6; it++) begin
      bus_write(32'h8, 32'h0, 4'h1);
      n = $urandom_range(1, 4);
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
        d = $urandom;
        m = 4'($urandom);
        m[0] = 1'b1;
        exp_q.push_back(d[7:0]);
        bus_write(32'h0, d, m);
      end
      read_check("rand_status", 32'h4, (n == 4) ? 32'h1 : 32'h0);
      repeat ($urandom_range(0, 5)) @(negedge clk);
      bus_write(32'h8, 32'h1, 4'h1);
      wait_busy(1);
      check_wave("rand");
      read_check("rand_status_end", 32'h4, 32'h2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
